alarm_sequencer: RTL



---
 rtl/alarm_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: drives system_state / passcode_state / timer / siren for the status display.
// Optional wrong-digit lockout is built when LOCKOUT_EN is defined.
module alarm_sequencer #(
   parameter int          CLK_HZ      = 50000000,
   parameter int          COUNTDOWN_S = 30,
   parameter logic [15:0] PASSCODE    = 16'h1234
`ifdef LOCKOUT_EN
   ,
   parameter int          MAX_WRONG   = 3
`endif
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       arm,
   input  logic       sensor,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   output logic [1:0] system_state,
   output logic [2:0] passcode_state,
   output logic [7:0] timer,
   output logic       siren
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SET     = 2'd1,
      TRIGGER = 2'd2,
      ALERT   = 2'd3
   } sys_state_t;

   localparam int          PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
   localparam logic [7:0]  COUNT_INIT = 8'(COUNTDOWN_S);
   localparam logic [2:0]  PC_DONE  = 3'd4;

   sys_state_t    state_q;
   logic [2:0]    pc_q;
   logic [7:0]    timer_q;
   logic          siren_q;
   logic [PW-1:0] prescaler_q;

`ifdef LOCKOUT_EN
   localparam logic [2:0] WRONG_LAST = 3'(MAX_WRONG - 1);
   logic [2:0] wrong_q;
`endif

   function automatic logic [3:0] code_digit(input logic [2:0] k);
      case (k)
         3'd0:    code_digit = PASSCODE[15:12];
         3'd1:    code_digit = PASSCODE[11:8];
         3'd2:    code_digit = PASSCODE[7:4];
         default: code_digit = PASSCODE[3:0];
      endcase
   endfunction

   logic digit_ok;
   logic digit_restart;
   assign digit_ok      = (digit <= 4'd9) && (digit == code_digit(pc_q));
   assign digit_restart = (digit <= 4'd9) && (digit == PASSCODE[15:12]);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pc_q        <= 3'd0;
         timer_q     <= COUNT_INIT;
         siren_q     <= 1'b0;
         prescaler_q <= '0;
`ifdef LOCKOUT_EN
         wrong_q     <= 3'd0;
`endif
      end else if (pc_q == PC_DONE) begin
         // Full passcode was shown for one cycle: disarm, overriding all other events.
         state_q     <= IDLE;
         pc_q        <= 3'd0;
         timer_q     <= COUNT_INIT;
         siren_q     <= 1'b0;
         prescaler_q <= '0;
`ifdef LOCKOUT_EN
         wrong_q     <= 3'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_q <= SET;
                  pc_q    <= 3'd0;
`ifdef LOCKOUT_EN
                  wrong_q <= 3'd0;
`endif
               end
            end
            SET: begin
               if (sensor) begin
                  state_q     <= TRIGGER;
                  timer_q     <= COUNT_INIT;
                  prescaler_q <= '0;
               end
            end
            TRIGGER: begin
               if (prescaler_q == PS_LAST) begin
                  prescaler_q <= '0;
                  if (timer_q == 8'd1) begin
                     state_q <= ALERT;
                     timer_q <= 8'd0;
                     siren_q <= 1'b1;
                  end else if (timer_q != 8'd0) begin
                     timer_q <= timer_q - 8'd1;
                  end
               end else begin
                  prescaler_q <= prescaler_q + 1'b1;
               end
            end
            default: begin
               siren_q <= 1'b1;
               timer_q <= 8'd0;
            end
         endcase

         // Passcode tracking runs in every armed state, alongside the state moves above.
         if (state_q != IDLE && digit_valid) begin
            if (digit_ok) begin
               pc_q <= pc_q + 3'd1;
            end else begin
               pc_q <= digit_restart ? 3'd1 : 3'd0;
`ifdef LOCKOUT_EN
               if (state_q != ALERT) begin
                  if (wrong_q != 3'd7) wrong_q <= wrong_q + 3'd1;
                  if (wrong_q >= WRONG_LAST) begin
                     state_q <= ALERT;
                     timer_q <= 8'd0;
                     siren_q <= 1'b1;
                     pc_q    <= 3'd0;
                  end
               end
`endif
            end
         end
      end
   end

   assign system_state   = state_q;
   assign passcode_state = pc_q;
   assign timer          = timer_q;
   assign siren          = siren_q;

endmodule
